miyajiro_uart_tx: RTL and testbench

- Memory-mapped UART transmit peripheral for MIYAJIRO_CPU; it is the responder end of the CPU's byte-output store path.
- The CPU core writes bytes into a small FIFO. The block serialises them as 8N1 frames on txd.
- It lets the CPU stream output to a host without stalling on every byte.
- It sits beside the data-memory port and is decoded by the CPU's I/O address select.

---
 rtl/miyajiro_uart_pkg.sv | 29 ++
 rtl/miyajiro_sync_fifo.sv | 74 +++++++
 rtl/miyajiro_uart_tx.sv | 165 ++++++++++++++++
 tb/tb_miyajiro_uart_tx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/miyajiro_uart_pkg.sv
// Shared definitions for the MIYAJIRO UART transmit path: FSM state
// encoding, frame geometry and a small shift helper.
package miyajiro_uart_pkg;

  // Transmit FSM states; the encoding is fixed so other tooling in the
  // codebase can decode the state from a debug tap.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Frame geometry: 8 data bits, no parity, one stop bit.
  localparam int UART_DATA_W    = 8;
  localparam int UART_STOP_BITS = 1;

  // Index of the last data bit and last stop bit, for the bit counter.
  localparam logic [2:0] LAST_DATA_BIT = 3'(UART_DATA_W - 1);
  localparam logic [2:0] LAST_STOP_BIT = 3'(UART_STOP_BITS - 1);

  // Advance the LSB-first shift register by one bit.
  function automatic logic [UART_DATA_W-1:0] shift_lsb_first(
    input logic [UART_DATA_W-1:0] value
  );
    return {1'b0, value[UART_DATA_W-1:1]};
  endfunction

endpackage

// File: rtl/miyajiro_sync_fifo.sv
// Byte-wide synchronous FIFO for the UART transmit queue.
// Depth is 2**AW. Pointers are AW bits and wrap naturally; the occupancy
// counter is one bit wider so it can tell "full" apart from "empty".
// Reset is asynchronous and active-high on the port named reset_n.
// Push while full and pop while empty are ignored here, so the caller
// may present either strobe unconditionally.
module miyajiro_sync_fifo
  import miyajiro_uart_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [UART_DATA_W-1:0] din,
  output logic [UART_DATA_W-1:0] dout,
  output logic [AW:0]            count,
  output logic                   full,
  output logic                   empty
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]          wptr_reg;
  logic [AW-1:0]          rptr_reg;
  logic [AW:0]            count_reg;
  logic                   push_ok;
  logic                   pop_ok;

  // Full/empty come straight from the current occupancy, so a push in the
  // same cycle as a pop from a full queue is still refused.
  assign full    = (count_reg == DEPTH_CNT);
  assign empty   = (count_reg == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign count   = count_reg;

  // The head byte is visible without latency so the transmitter can load
  // it into its shift register on the very edge it pops.
  assign dout = mem[rptr_reg];

  // Storage write; contents need no reset because the pointers define
  // which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr_reg] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push_ok) begin
        wptr_reg <= wptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rptr_reg <= rptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/miyajiro_uart_tx.sv
// Memory-mapped UART transmitter for MIYAJIRO_CPU.
// CPU stores land in a small FIFO; an FSM drains it as 8N1 frames on txd.
// A new frame begins one cycle after a byte is accepted into an empty
// queue, and queued bytes follow with no idle gap between frames.
// Reset is asynchronous and active-high on the port named reset_n; it
// forces txd high at once and discards both the frame and the queue.
module miyajiro_uart_tx
  import miyajiro_uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_AW     = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic [FIFO_AW:0]       fifo_count,
  output logic                   busy,
  output logic                   overflow,
  output logic                   txd
);

  // CLK_PER_BIT >= 2, so the counter is always at least one bit wide.
  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_PER_BIT - 1);

  tx_state_t              state_reg;
  logic [CNT_W-1:0]       baud_cnt_reg;
  logic [2:0]             bit_idx_reg;
  logic [UART_DATA_W-1:0] shift_reg;
  logic                   txd_reg;
  logic                   overflow_reg;

  logic [UART_DATA_W-1:0] fifo_dout;
  logic [FIFO_AW:0]       fifo_cnt;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic                   bit_end;
  logic                   stop_done;

  // Byte queue between the CPU store path and the serialiser.
  miyajiro_sync_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr_en),
    .pop     (fifo_pop),
    .din     (wr_data),
    .dout    (fifo_dout),
    .count   (fifo_cnt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A bit period ends on the last count of the baud counter; the frame
  // ends when the last stop bit's period ends.
  assign bit_end   = (baud_cnt_reg == BAUD_LAST);
  assign stop_done = (state_reg == STOP) && bit_end &&
                     (bit_idx_reg == LAST_STOP_BIT);

  // Pop whenever the FSM is ready for a new byte and one is waiting: from
  // IDLE, or at the end of a stop bit so the next start bit is contiguous.
  assign fifo_pop = ~fifo_empty && ((state_reg == IDLE) || stop_done);

  assign full       = fifo_full;
  assign fifo_count = fifo_cnt;
  assign busy       = (state_reg != IDLE) || ~fifo_empty;
  assign overflow   = overflow_reg;
  assign txd        = txd_reg;

  // Frame sequencer: baud timing, bit counting, shifting and the
  // registered line level all advance together.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      txd_reg      <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          txd_reg      <= 1'b1;
          baud_cnt_reg <= '0;
          bit_idx_reg  <= '0;
          if (!fifo_empty) begin
            shift_reg <= fifo_dout;
            txd_reg   <= 1'b0;
            state_reg <= START;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            txd_reg      <= shift_reg[0];
            state_reg    <= DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            if (bit_idx_reg == LAST_DATA_BIT) begin
              bit_idx_reg <= '0;
              txd_reg     <= 1'b1;
              state_reg   <= STOP;
            end else begin
              // Next bit on the line is what will be at shift[0] after
              // this shift, i.e. the current shift[1].
              shift_reg   <= shift_lsb_first(shift_reg);
              txd_reg     <= shift_reg[1];
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

        STOP: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            if (bit_idx_reg == LAST_STOP_BIT) begin
              bit_idx_reg <= '0;
              if (!fifo_empty) begin
                shift_reg <= fifo_dout;
                txd_reg   <= 1'b0;
                state_reg <= START;
              end else begin
                txd_reg   <= 1'b1;
                state_reg <= IDLE;
              end
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          txd_reg   <= 1'b1;
        end
      endcase
    end
  end

  // Sticky overflow: any store attempted against a full queue is recorded
  // until the next reset.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      overflow_reg <= 1'b0;
    end else if (wr_en && fifo_full) begin
      overflow_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_miyajiro_uart_tx.sv
// Bench for miyajiro_uart_tx with CLK_PER_BIT=4, FIFO_AW=2.
// Stimulus pushes {byte, expected start cycle} into a scoreboard queue;
// a monitor decodes every frame seen on txd and checks it against the
// queue head.
module tb_miyajiro_uart_tx;

  localparam int CPB   = 4;
  localparam int AW    = 2;
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          full;
  logic [AW:0]   fifo_count;
  logic          busy;
  logic          overflow;
  logic          txd;

  miyajiro_uart_tx #(
    .CLK_PER_BIT (CPB),
    .FIFO_AW     (AW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .fifo_count (fifo_count),
    .busy       (busy),
    .overflow   (overflow),
    .txd        (txd)
  );

  always #5 clk = ~clk;

  // cyc holds the index of the most recent rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;
  exp_t exp_q[$];

  task automatic expect_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input int start);
    exp_t e;
    e.data  = d;
    e.start = start;
    exp_q.push_back(e);
  endtask

  // Drive one store strobe; returns the index of the edge that sampled it.
  task automatic do_write(input logic [7:0] d, output int edge_idx);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en    = 1'b0;
    edge_idx = cyc;
    $display("write 0x%0h sampled at edge %0d", d, edge_idx);
  endtask

  task automatic wait_to(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- monitor ----------------
  logic       mon_s [FRAME];
  logic [7:0] mon_byte;
  int         mon_start;
  bit         mon_abort;
  bit         mon_stable;
  exp_t       mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n == 1'b0 && txd == 1'b0) begin
        mon_start = cyc;
        mon_abort = 1'b0;
        mon_s[0]  = 1'b0;
        for (int k = 1; k < FRAME; k++) begin
          @(negedge clk);
          if (reset_n) begin
            mon_abort = 1'b1;
            break;
          end
          mon_s[k] = txd;
        end
        if (mon_abort) begin
          $display("frame starting at cycle %0d abandoned by reset", mon_start);
        end else begin
          mon_stable = 1'b1;
          for (int b = 0; b < 10; b++)
            for (int c = 1; c < CPB; c++)
              if (mon_s[b*CPB+c] != mon_s[b*CPB]) mon_stable = 1'b0;
          for (int i = 0; i < 8; i++) mon_byte[i] = mon_s[(i+1)*CPB];
          $display("frame 0x%0h started at cycle %0d", mon_byte, mon_start);
          expect_eq("bit_stable", int'(mon_stable), 1);
          expect_eq("stop_bit", int'(mon_s[9*CPB]), 1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: got byte 0x%0h at cycle %0d, none expected",
                     mon_byte, mon_start);
          end else begin
            mon_e = exp_q.pop_front();
            expect_eq("frame_data", int'(mon_byte), int'(mon_e.data));
            expect_eq("frame_start_cycle", mon_start, mon_e.start);
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int e;
    int e2;
    bit saw_low;

    // Reset values
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_eq("reset_txd", int'(txd), 1);
    expect_eq("reset_busy", int'(busy), 0);
    expect_eq("reset_full", int'(full), 0);
    expect_eq("reset_count", int'(fifo_count), 0);
    expect_eq("reset_overflow", int'(overflow), 0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;

    // Single byte: start bit one cycle after accept, busy clears after 40
    do_write(8'hA5, e);
    push_exp(8'hA5, e + 1);
    expect_eq("single_count", int'(fifo_count), 1);
    wait_to(e + FRAME);
    expect_eq("single_busy_last_stop", int'(busy), 1);
    wait_to(e + FRAME + 1);
    expect_eq("single_busy_after", int'(busy), 0);
    expect_eq("single_txd_idle", int'(txd), 1);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back: second frame immediately follows the first stop bit
    do_write(8'h01, e);
    push_exp(8'h01, e + 1);
    expect_eq("b2b_count_1", int'(fifo_count), 1);
    do_write(8'h80, e2);
    push_exp(8'h80, e + 1 + FRAME);
    expect_eq("b2b_count_2", int'(fifo_count), 1);
    wait_to(e + FRAME);
    expect_eq("b2b_count_pre_pop", int'(fifo_count), 1);
    wait_to(e + FRAME + 1);
    expect_eq("b2b_count_post_pop", int'(fifo_count), 0);
    wait_to(e + 2 * FRAME + 1);
    expect_eq("b2b_busy_after", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;

    // Full/overflow: fifth queued write is dropped
    do_write(8'h3C, e);
    push_exp(8'h3C, e + 1);
    for (int i = 0; i < 5; i++) begin
      do_write(8'h10 + 8'(i), e2);
      if (i < 4) push_exp(8'h10 + 8'(i), e + 1 + (i + 1) * FRAME);
      if (i == 3) begin
        expect_eq("full_count4", int'(fifo_count), 4);
        expect_eq("full_flag", int'(full), 1);
        expect_eq("full_no_overflow_yet", int'(overflow), 0);
      end
    end
    expect_eq("ovf_set", int'(overflow), 1);
    expect_eq("ovf_count_unchanged", int'(fifo_count), 4);
    wait_to(e + 5 * FRAME + 1);
    expect_eq("ovf_drained_busy", int'(busy), 0);
    expect_eq("ovf_sticky", int'(overflow), 1);

    // Reset clears overflow
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    expect_eq("ovf_cleared", int'(overflow), 0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;

    // Write while full coinciding with the STOP->START pop
    do_write(8'h3C, e);
    push_exp(8'h3C, e + 1);
    for (int i = 0; i < 4; i++) begin
      do_write(8'h10 + 8'(i), e2);
      push_exp(8'h10 + 8'(i), e + 1 + (i + 1) * FRAME);
    end
    wait_to(e + FRAME);
    expect_eq("popwr_count_before", int'(fifo_count), 4);
    expect_eq("popwr_full_before", int'(full), 1);
    do_write(8'h77, e2);
    expect_eq("popwr_edge", e2, e + FRAME + 1);
    expect_eq("popwr_overflow", int'(overflow), 1);
    expect_eq("popwr_count_after", int'(fifo_count), 3);
    expect_eq("popwr_full_after", int'(full), 0);
    wait_to(e + 5 * FRAME + 1);
    expect_eq("popwr_busy_after", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-frame during data bit 3 (a zero bit of 0xA5)
    do_write(8'hA5, e);
    push_exp(8'hA5, e + 1);
    wait_to(e + 1 + CPB + 3 * CPB + 1);
    #1;
    expect_eq("midrst_bit3_low", int'(txd), 0);
    reset_n = 1'b1;
    #1;
    expect_eq("midrst_txd_async", int'(txd), 1);
    expect_eq("midrst_busy_async", int'(busy), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    expect_eq("midrst_count", int'(fifo_count), 0);
    saw_low = 1'b0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (txd == 1'b0) saw_low = 1'b1;
    end
    expect_eq("midrst_no_residual", int'(saw_low), 0);

    expect_eq("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
